// File: rtl/key_led_ctrl.sv
// Two-key LED rotator: each key is synchronized and debounced, then drives a
// short/long-press FSM that emits rotation steps; key 0 rotates left, key 1 right.
`timescale 1ns/1ps
module key_led_ctrl #(
    parameter int DEBOUNCE_CYCLES = 540000,
    parameter int LONG_CYCLES     = 27000000,
    parameter int REPEAT_CYCLES   = 13500000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [1:0] key,
    output logic [5:0] led,
    output logic [1:0] key_down,
    output logic [1:0] step_pulse
);

    localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HMAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int HW   = (HMAX > 1) ? $clog2(HMAX) : 1;

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } state_e;

    // Synchronizer resets to the released (high) level so a held key is re-seen as a new edge.
    logic [1:0] sync1_q, sync2_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
        end else begin
            sync1_q <= key;
            sync2_q <= sync1_q;
        end
    end

    for (genvar k = 0; k < 2; k++) begin : g_key
        logic          pressed;
        logic [DW-1:0] db_cnt_q, db_cnt_d;
        logic          kd_q, kd_d;
        state_e        state_q, state_d;
        logic [HW-1:0] hold_q, hold_d;
        logic          step_q, step_d;

        assign pressed = ~sync2_q[k];

        always_comb begin
            db_cnt_d = '0;
            kd_d     = kd_q;
            if (pressed != kd_q) begin
                if (db_cnt_q == DEB_LAST) begin
                    kd_d = ~kd_q;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
        end

        // Release wins over a coinciding hold expiry, so letting go never repeats.
        always_comb begin
            state_d = state_q;
            hold_d  = hold_q;
            step_d  = 1'b0;
            case (state_q)
                IDLE: begin
                    hold_d = '0;
                    if (kd_q) begin
                        state_d = PRESSED;
                    end
                end
                PRESSED: begin
                    if (!kd_q) begin
                        state_d = IDLE;
                        step_d  = 1'b1;
                    end else if (hold_q == LONG_LAST) begin
                        state_d = HELD;
                        step_d  = 1'b1;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                HELD: begin
                    if (!kd_q) begin
                        state_d = IDLE;
                    end else if (hold_q == REP_LAST) begin
                        step_d = 1'b1;
                        hold_d = '0;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    hold_d  = '0;
                end
            endcase
        end

        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                db_cnt_q <= '0;
                kd_q     <= 1'b0;
                state_q  <= IDLE;
                hold_q   <= '0;
                step_q   <= 1'b0;
            end else begin
                db_cnt_q <= db_cnt_d;
                kd_q     <= kd_d;
                state_q  <= state_d;
                hold_q   <= hold_d;
                step_q   <= step_d;
            end
        end

        assign key_down[k]   = kd_q;
        assign step_pulse[k] = step_q;
    end

    logic [5:0] led_q, led_d;

    always_comb begin
        case (step_pulse)
            2'b01:   led_d = {led_q[4:0], led_q[5]};
            2'b10:   led_d = {led_q[0], led_q[5:1]};
            default: led_d = led_q;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            led_q <= 6'b111110;
        end else begin
            led_q <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: tb/tb_key_led_ctrl.sv
// Directed bench for key_led_ctrl with short debounce/hold parameters.
`timescale 1ns/1ps
module tb_key_led_ctrl;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b1;
    logic [1:0] key       = 2'b11;
    logic [5:0] led;
    logic [1:0] key_down;
    logic [1:0] step_pulse;

    int ncmp = 0;
    int nerr = 0;
    int pc0  = 0;
    int pc1  = 0;
    int p0, p1;

    key_led_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES    (20),
        .REPEAT_CYCLES  (8)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key       (key),
        .led       (led),
        .key_down  (key_down),
        .step_pulse(step_pulse)
    );

    always #5 sys_clk = ~sys_clk;

    // Pulse tally, sampled mid-cycle.
    always @(negedge sys_clk) begin
        if (step_pulse[0]) pc0 <= pc0 + 1;
        if (step_pulse[1]) pc1 <= pc1 + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        tick(2);
        sys_rst_n = 1'b1;
        tick(2);
    endtask

    initial begin
        // Asynchronous reset, checked before any clock edge
        #1 sys_rst_n = 1'b0;
        #1;
        chk("rst_led",  8'(led),        8'h3E);
        chk("rst_kd",   8'(key_down),   8'h00);
        chk("rst_step", 8'(step_pulse), 8'h00);
        tick(3);
        sys_rst_n = 1'b1;

        // Idle for 100 cycles
        for (int i = 0; i < 100; i++) begin
            tick(1);
            chk("idle_led",  8'(led),        8'h3E);
            chk("idle_step", 8'(step_pulse), 8'h00);
        end

        // 3-cycle glitch on key[0] is rejected
        key = 2'b10;
        tick(3);
        key = 2'b11;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("glitch_kd",  8'(key_down), 8'h00);
            chk("glitch_led", 8'(led),      8'h3E);
        end
        chk("glitch_pc0", 8'(pc0), 8'd0);

        // Short press key[0]: 10 cycles low
        key = 2'b10;
        tick(5);
        chk("short_kd_e5", 8'(key_down), 8'h00);
        tick(1);
        chk("short_kd_e6", 8'(key_down), 8'h01);
        tick(4);
        key = 2'b11;
        tick(7);
        chk("short_step_e17", 8'(step_pulse), 8'h01);
        chk("short_led_e17",  8'(led),        8'h3E);
        tick(1);
        chk("short_step_e18", 8'(step_pulse), 8'h00);
        chk("short_led_e18",  8'(led),        8'h3D);
        tick(20);
        chk("short_led_hold", 8'(led), 8'h3D);
        chk("short_pc0",      8'(pc0), 8'd1);

        // Long hold key[1]: 60 cycles
        do_reset();
        chk("rst2_led", 8'(led), 8'h3E);
        p1 = pc1;
        key = 2'b01;
        tick(26);
        chk("long_step_e26", 8'(step_pulse), 8'h00);
        tick(1);
        chk("long_step_e27", 8'(step_pulse), 8'h02);
        tick(1);
        chk("long_led_e28",  8'(led),        8'h1F);
        chk("long_step_e28", 8'(step_pulse), 8'h00);
        tick(7);
        chk("long_step_e35", 8'(step_pulse), 8'h02);
        tick(1);
        chk("long_led_e36", 8'(led), 8'h2F);
        tick(24);
        chk("long_led_e60", 8'(led), 8'h3D);
        key = 2'b11;
        tick(10);
        chk("long_led_end", 8'(led),      8'h3D);
        chk("long_pc1",     8'(pc1 - p1), 8'd5);
        chk("long_kd_end",  8'(key_down), 8'h00);

        // Simultaneous short press on both keys
        do_reset();
        p0 = pc0;
        p1 = pc1;
        key = 2'b00;
        tick(6);
        chk("both_kd", 8'(key_down), 8'h03);
        tick(4);
        key = 2'b11;
        tick(7);
        chk("both_step", 8'(step_pulse), 8'h03);
        tick(1);
        chk("both_led", 8'(led), 8'h3E);
        tick(5);
        chk("both_pc0",     8'(pc0 - p0), 8'd1);
        chk("both_pc1",     8'(pc1 - p1), 8'd1);
        chk("both_led_end", 8'(led),      8'h3E);

        // Reset pulse while key[0] is in HELD
        do_reset();
        key = 2'b10;
        tick(27);
        chk("mid_step_e27", 8'(step_pulse), 8'h01);
        tick(1);
        chk("mid_led_e28", 8'(led), 8'h3D);
        tick(2);
        sys_rst_n = 1'b0;
        #1;
        chk("mid_rst_led",  8'(led),        8'h3E);
        chk("mid_rst_step", 8'(step_pulse), 8'h00);
        chk("mid_rst_kd",   8'(key_down),   8'h00);
        tick(1);
        sys_rst_n = 1'b1;
        p0 = pc0;
        tick(5);
        chk("mid_kd_r5", 8'(key_down), 8'h00);
        tick(1);
        chk("mid_kd_r6", 8'(key_down), 8'h01);
        tick(20);
        chk("mid_step_r26", 8'(step_pulse), 8'h00);
        chk("mid_pc0_r26",  8'(pc0 - p0),   8'd0);
        chk("mid_led_r26",  8'(led),        8'h3E);
        tick(1);
        chk("mid_step_r27", 8'(step_pulse), 8'h01);
        tick(1);
        chk("mid_led_r28", 8'(led), 8'h3D);
        key = 2'b11;
        tick(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
